ahbl_to_axi_bridge: RTL
=======================

# ahbl_to_axi_bridge

Single-clock bridge that accepts AHB-Lite slave transfers and converts each one into a single-beat AXI master transaction, so that AHB-Lite masters in the fabric can reach 64-bit AXI slaves. It is the reverse of the AXI-to-AHB-Lite bridge: here AHB is the target side and AXI is the initiator side. Transfers are non-posted. HREADYOUT stays low until the AXI response returns.

## Interface
- ID_WIDTH, 6, width of AWID/ARID.
- HCLK  in  1  clock for both the AHB and AXI sides.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  32  address-phase address.
- HTRANS  in  2  transfer type; NONSEQ and SEQ are valid, IDLE and BUSY are ignored.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size; 0/1/2 are legal.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-level ready.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  1 = ERROR.
- HRDATA  out  32  read data.
- AWADDR, ARADDR  out  32  captured HADDR.
- AWSIZE, ARSIZE  out  3  captured HSIZE.
- AWID, ARID (ID_WIDTH), AWLEN, ARLEN (4), AWBURST, ARBURST (2)  out  constants: 0, 0, INCR (2'b01).
- AWVALID / AWREADY  out / in  1  write-address handshake.
- WDATA  out  64  {HWDATA_q, HWDATA_q}.
- WSTRB  out  8  byte enables.
- WLAST  out  1  constant 1.
- WVALID / WREADY  out / in  1  write-data handshake.
- BRESP  in  2; BVALID  in  1; BREADY  out  1.
- ARVALID / ARREADY  out / in  1  read-address handshake.
- RDATA  in  64; RRESP  in  2; RLAST  in  1 (ignored); RVALID  in  1; RREADY  out  1.

## Operation
- **Accept condition:** HSEL & HTRANS[1] & HREADY, sampled in IDLE or ERR2. On accept, capture HADDR, HWRITE and HSIZE.
- **State machine:** IDLE, WR_DATA, WR_REQ, WR_RESP, RD_REQ, RD_RESP, ERR1, ERR2.
- **IDLE:**
  - Accepted write goes to WR_DATA.
  - Accepted read goes to RD_REQ.
  - Accepted transfer with HSIZE >= 3 goes to ERR1 and issues no AXI transaction.
  - Non-accepted cycles stay in IDLE with an OKAY, zero-wait response.
- **WR_DATA:** capture HWDATA, then go to WR_REQ.
- **WR_REQ:**
  - Assert AWVALID and WVALID.
  - Each one drops independently on its own handshake.
  - When both channels are done, go to WR_RESP.
- **WR_RESP:** BREADY=1. On BVALID, go to IDLE if BRESP[1]=0, else go to ERR1.
- **RD_REQ:** ARVALID=1 until ARREADY, then go to RD_RESP.
- **RD_RESP:**
  - RREADY=1.
  - On RVALID, load HRDATA from RDATA[63:32] if captured HADDR[2]=1, else from RDATA[31:0].
  - Then go to IDLE if RRESP[1]=0, else go to ERR1.
- **Error states:** ERR1 drives HREADYOUT=0, HRESP=1. ERR2 drives HREADYOUT=1, HRESP=1. ERR2 then behaves as IDLE for the accept decision.
- **WSTRB:**
  - Byte (HSIZE 0): 8'b1 << A[2:0].
  - Halfword (HSIZE 1): 8'b11 << {A[2:1], 1'b0}.
  - Word (HSIZE 2): 8'b1111 << {A[2], 2'b00}.
  - A is the captured address.
- **Address alignment:** unaligned addresses are passed through unchanged. Alignment is the master's responsibility.

## Timing
- **Outputs are registered.** HREADYOUT drops on the clock edge that accepts the transfer.
- **Reset values:**
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - All VALID and READY outputs = 0.
  - AWADDR, ARADDR, WDATA, WSTRB, AWSIZE, ARSIZE = 0.
  - State = IDLE.
- **Reset mid-transaction:** HRESET forces the reset values immediately and abandons any AXI transaction in flight.
- **Write latency (zero-wait AXI slave):**
  - Address phase in cycle 0.
  - WR_DATA in cycle 1.
  - AWVALID/WVALID in cycle 2.
  - BREADY in cycle 3.
  - HREADYOUT=1 in cycle 4.
- **Read latency (zero-wait AXI slave):**
  - Address phase in cycle 0.
  - ARVALID in cycle 1.
  - RREADY in cycle 2.
  - HREADYOUT=1 with valid HRDATA in cycle 3.
- **Back-to-back transfers:** a transfer presented in the completion cycle (HREADYOUT=1) is accepted in that same cycle.
- **AXI handshake rules:**
  - VALID is never withdrawn before READY.
  - AW and W may complete in either order or in the same cycle.
  - A B or R beat arriving in the same cycle as the last handshake is accepted only in the RESP state, i.e. at the earliest one cycle later.
- **AHB error response:** exactly two cycles, ERR1 then ERR2.

## Test plan
- **Reset:** assert HRESET mid-WR_REQ with AWVALID=1 -> all outputs drop to reset values in the same cycle, and HREADYOUT=1.
- **Byte write:** HADDR=0x1000_0005, HSIZE=0, HWDATA=0x0000_AB00, zero-wait slave -> AWADDR=0x1000_0005, WSTRB=0x20, WDATA=0x0000_AB00_0000_AB00, HREADYOUT low for cycles 1-3 and high in cycle 4.
- **Word read, upper lane:** HADDR=0x2000_0004, RDATA=0x1122_3344_5566_7788 -> HRDATA=0x1122_3344, HRESP=0.
- **Write handshake ordering:** WREADY arrives 3 cycles before AWREADY -> WVALID drops after its handshake, AWVALID is held until AWREADY, and exactly one B handshake follows.
- **Read slave error:** RRESP=2'b10 -> HRESP=1 with HREADYOUT 0 then 1, then return to IDLE. Separately, HSIZE=3 -> ERROR response with no ARVALID asserted.
- **Back-to-back and ignored transfers:**
  - A SEQ write presented in a read's completion cycle -> accepted with no idle gap.
  - HTRANS=BUSY or HSEL=0 -> no AXI activity and HREADYOUT stays 1.

Source files
------------

// File: rtl/ahbl_to_axi_bridge.sv
// AHB-Lite slave to AXI master bridge.
// Each accepted AHB-Lite transfer becomes one single-beat AXI transaction on a
// 64-bit data bus. Transfers are non-posted: HREADYOUT stays low until the AXI
// response has come back. All outputs come straight from flops.
module ahbl_to_axi_bridge #(
    parameter int unsigned ID_WIDTH = 6
) (
    input  logic                HCLK,
    input  logic                HRESET,

    // AHB-Lite slave side
    input  logic                HSEL,
    input  logic [31:0]         HADDR,
    input  logic [1:0]          HTRANS,
    input  logic                HWRITE,
    input  logic [2:0]          HSIZE,
    input  logic [31:0]         HWDATA,
    input  logic                HREADY,
    output logic                HREADYOUT,
    output logic                HRESP,
    output logic [31:0]         HRDATA,

    // AXI write address channel
    output logic [31:0]         AWADDR,
    output logic [2:0]          AWSIZE,
    output logic [ID_WIDTH-1:0] AWID,
    output logic [3:0]          AWLEN,
    output logic [1:0]          AWBURST,
    output logic                AWVALID,
    input  logic                AWREADY,

    // AXI write data channel
    output logic [63:0]         WDATA,
    output logic [7:0]          WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY,

    // AXI write response channel
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY,

    // AXI read address channel
    output logic [31:0]         ARADDR,
    output logic [2:0]          ARSIZE,
    output logic [ID_WIDTH-1:0] ARID,
    output logic [3:0]          ARLEN,
    output logic [1:0]          ARBURST,
    output logic                ARVALID,
    input  logic                ARREADY,

    // AXI read data channel
    input  logic [63:0]         RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RLAST,
    input  logic                RVALID,
    output logic                RREADY
);

    typedef enum logic [2:0] {
        StIdle,
        StWrData,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdResp,
        StErr1,
        StErr2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic [31:0] hrdata_q, hrdata_d;
    logic        hreadyout_q, hreadyout_d;
    logic        hresp_q, hresp_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        arvalid_q, arvalid_d;
    logic        bready_q, bready_d;
    logic        rready_q, rready_d;

    logic        accept;
    logic [7:0]  strb_calc;

    // Single-beat transactions: the last flag and the low response bits carry
    // nothing the bridge acts on, and HTRANS[0] only separates SEQ from NONSEQ.
    logic        unused_inputs;
    assign unused_inputs = ^{RLAST, BRESP[0], RRESP[0], HTRANS[0]};

    // A new transfer is taken only when this slave is selected, the transfer is
    // NONSEQ/SEQ and the bus is not stalled by a previous data phase.
    assign accept = HSEL & HTRANS[1] & HREADY;

    // Byte lanes on the 64-bit bus for the captured address and size.
    always_comb begin
        strb_calc = 8'h00;
        case (size_q)
            3'd0:    strb_calc = 8'b0000_0001 << addr_q[2:0];
            3'd1:    strb_calc = 8'b0000_0011 << {addr_q[2:1], 1'b0};
            3'd2:    strb_calc = 8'b0000_1111 << {addr_q[2], 2'b00};
            default: strb_calc = 8'h00;
        endcase
    end

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        hrdata_d  = hrdata_q;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;

        case (state_q)
            // ERR2 already shows HREADYOUT=1, so it takes new transfers like IDLE.
            StIdle, StErr2: begin
                if (accept) begin
                    addr_d = HADDR;
                    size_d = HSIZE;
                    if (HSIZE >= 3'd3) begin
                        state_d = StErr1;
                    end else if (HWRITE) begin
                        state_d = StWrData;
                    end else begin
                        state_d = StRdReq;
                    end
                end else begin
                    state_d = StIdle;
                end
            end

            StWrData: begin
                wdata_d   = HWDATA;
                wstrb_d   = strb_calc;
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                state_d   = StWrReq;
            end

            // AW and W retire independently; move on once neither is pending.
            StWrReq: begin
                awvalid_d = awvalid_q & ~AWREADY;
                wvalid_d  = wvalid_q & ~WREADY;
                if (!awvalid_d && !wvalid_d) begin
                    state_d = StWrResp;
                end
            end

            StWrResp: begin
                if (BVALID) begin
                    state_d = BRESP[1] ? StErr1 : StIdle;
                end
            end

            StRdReq: begin
                if (ARREADY) begin
                    state_d = StRdResp;
                end
            end

            StRdResp: begin
                if (RVALID) begin
                    hrdata_d = addr_q[2] ? RDATA[63:32] : RDATA[31:0];
                    state_d  = RRESP[1] ? StErr1 : StIdle;
                end
            end

            StErr1: begin
                state_d = StErr2;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Remaining outputs are a pure function of the state being entered, so
        // registering them makes them line up with that state.
        hreadyout_d = (state_d == StIdle) || (state_d == StErr2);
        hresp_d     = (state_d == StErr1) || (state_d == StErr2);
        arvalid_d   = (state_d == StRdReq);
        bready_d    = (state_d == StWrResp);
        rready_d    = (state_d == StRdResp);
    end

    // State and registered outputs; reset abandons any AXI transaction in flight.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= StIdle;
            addr_q      <= 32'h0;
            size_q      <= 3'd0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 8'h00;
            hrdata_q    <= 32'h0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            hrdata_q    <= hrdata_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;

    assign AWADDR    = addr_q;
    assign AWSIZE    = size_q;
    assign AWID      = '0;
    assign AWLEN     = 4'd0;
    assign AWBURST   = 2'b01;
    assign AWVALID   = awvalid_q;

    // 32-bit data is replicated on both halves; WSTRB selects the live lanes.
    assign WDATA     = {wdata_q, wdata_q};
    assign WSTRB     = wstrb_q;
    assign WLAST     = 1'b1;
    assign WVALID    = wvalid_q;

    assign BREADY    = bready_q;

    assign ARADDR    = addr_q;
    assign ARSIZE    = size_q;
    assign ARID      = '0;
    assign ARLEN     = 4'd0;
    assign ARBURST   = 2'b01;
    assign ARVALID   = arvalid_q;

    assign RREADY    = rready_q;

endmodule
